// File: rtl/alu_bitop_seq.sv
// Bit-operation sequencer: drives an external ALU through LDB/LDA/EXEC for
// BIT/RES/SET requests. Optional op_count port under ALU_BITOP_SEQ_COUNT_EN.
module alu_bitop_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [2:0]       req_bit,
  input  logic [7:0]       req_data,
  output logic [2:0]       alu_bs,
  output logic [7:0]       alu_op,
  output logic [1:0]       alu_oe,
  output logic             alu_la,
  output logic             alu_lb,
  output logic [6:0]       alu_ctl,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_z,
  output logic             rsp_err
`ifdef ALU_BITOP_SEQ_COUNT_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LDB, S_LDA, S_EXEC, S_RSP} state_t;

  localparam logic [1:0] K_BIT = 2'd0;
  localparam logic [1:0] K_RES = 2'd1;
  localparam logic [1:0] K_SET = 2'd2;
  localparam logic [1:0] K_RSV = 2'd3;

  localparam logic [1:0] OE_BS  = 2'd1;
  localparam logic [1:0] OE_SH  = 2'd2;
  localparam logic [1:0] OE_RES = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] kind_q;
  logic [2:0] bit_q;
  logic [7:0] data_q;
  logic       err_q;
  logic [7:0] rsp_data_q;
  logic       rsp_z_q;
  logic [6:0] ctl_base;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      kind_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_z_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (req_valid) begin
          kind_q     <= req_kind;
          bit_q      <= req_bit;
          data_q     <= req_data;
          err_q      <= (req_kind == K_RSV);
          rsp_data_q <= req_data;
          rsp_z_q    <= 1'b0;
        end
        S_LDA: if (kind_q != K_BIT && !alu_carry) err_q <= 1'b1;
        S_EXEC: begin
          if (kind_q != K_BIT && !alu_carry) err_q <= 1'b1;
          // BIT only tests: the operand is returned untouched, only Z matters
          rsp_data_q <= (kind_q == K_BIT) ? data_q : alu_result;
          rsp_z_q    <= alu_zero;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (kind_q)
      K_RES:   ctl_base = 7'b0101110;
      K_SET:   ctl_base = 7'b1000010;
      default: ctl_base = 7'b0000010;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_bs    = '0;
    alu_op    = '0;
    alu_oe    = '0;
    alu_la    = 1'b0;
    alu_lb    = 1'b0;
    alu_ctl   = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_kind == K_RSV) ? S_RSP : S_LDB;
      end
      S_LDB: begin
        alu_bs  = bit_q;
        alu_oe  = OE_BS;
        alu_lb  = 1'b1;
        state_d = S_LDA;
      end
      S_LDA: begin
        alu_op  = data_q;
        alu_oe  = OE_SH;
        alu_la  = 1'b1;
        alu_ctl = ctl_base;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_oe  = OE_RES;
        alu_ctl = {ctl_base[6:2], 2'b01};
        state_d = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_data = rsp_data_q;
  assign rsp_z    = rsp_z_q;
  assign rsp_err  = err_q;

`ifdef ALU_BITOP_SEQ_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) cnt_q <= '0;
    else if (rsp_valid && rsp_ready) cnt_q <= cnt_q + 1'b1;
  end

  assign op_count = cnt_q;
`endif

endmodule
